// File: rtl/vec_mode_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : vec_mode_scheduler
//  Purpose  : Control front-end for the vector datapath. Turns six level mode
//             switches into a latched opcode and walks the datapath across
//             NUM_BLOCKS blocks using a start/done handshake.
//             Optional build macro VEC_MODE_SYNC_EN puts a 2-flop
//             synchronizer on each mode input.
//  Revision : 1.0 - initial release
// ============================================================================
module vec_mode_scheduler #(
    parameter int NUM_BLOCKS = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode_xor,
    input  logic              mode_rshift,
    input  logic              mode_lshift,
    input  logic              mode_ecae,
    input  logic              mode_dcae,
    input  logic              mode_mul,
    input  logic              proc_ready,
    input  logic              proc_done,
    output logic [2:0]        op,
    output logic [ADDR_W-1:0] blk_addr,
    output logic              start,
    output logic              busy,
    output logic              run_done,
    output logic              mode_err
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [ADDR_W-1:0] c_last_blk = ADDR_W'(NUM_BLOCKS - 1);

    logic [5:0]        w_mode_raw;
    logic [5:0]        w_mode;
    logic [2:0]        w_mode_cnt;
    logic [2:0]        w_mode_op;
    logic              w_mode_any;
    logic              w_mode_one;
    logic              w_mode_multi;

    logic [1:0]        r_state;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_blk_addr;
    logic              r_start;
    logic              r_busy;
    logic              r_run_done;
    logic              r_mode_err;

    // Bit order matches opcode order: bit i corresponds to opcode i+1.
    assign w_mode_raw = {mode_mul, mode_dcae, mode_ecae, mode_lshift, mode_rshift, mode_xor};

`ifdef VEC_MODE_SYNC_EN
    logic [5:0] r_mode_s1;
    logic [5:0] r_mode_s2;

    // Two-flop synchronizer on every mode switch before the FSM looks at it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode_s1 <= '0;
            r_mode_s2 <= '0;
        end else begin
            r_mode_s1 <= w_mode_raw;
            r_mode_s2 <= r_mode_s1;
        end
    end

    assign w_mode = r_mode_s2;
`else
    assign w_mode = w_mode_raw;
`endif

    // Population count of the active mode switches
    always_comb begin
        w_mode_cnt = 3'd0;
        for (int i = 0; i < 6; i++) begin
            w_mode_cnt = w_mode_cnt + {2'b00, w_mode[i]};
        end
    end

    // One-hot mode vector to opcode; only used when exactly one bit is set
    always_comb begin
        case (w_mode)
            6'b000001: w_mode_op = 3'd1;
            6'b000010: w_mode_op = 3'd2;
            6'b000100: w_mode_op = 3'd3;
            6'b001000: w_mode_op = 3'd4;
            6'b010000: w_mode_op = 3'd5;
            6'b100000: w_mode_op = 3'd6;
            default:   w_mode_op = 3'd0;
        endcase
    end

    assign w_mode_any   = |w_mode;
    assign w_mode_one   = (w_mode_cnt == 3'd1);
    assign w_mode_multi = (w_mode_cnt > 3'd1);

    // Run sequencer: latch opcode in IDLE, then issue/wait per block until the last one finishes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_st_idle;
            r_op       <= 3'd0;
            r_blk_addr <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_run_done <= 1'b0;
            r_mode_err <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_mode_one) begin
                        r_op       <= w_mode_op;
                        r_blk_addr <= '0;
                        r_busy     <= 1'b1;
                        r_mode_err <= 1'b0;
                        r_state    <= c_st_issue;
                    end else begin
                        r_mode_err <= w_mode_multi;
                    end
                end
                c_st_issue: begin
                    if (proc_ready) begin
                        r_start <= 1'b1;
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    // A done arriving together with ready still goes back through ISSUE,
                    // guaranteeing at least one idle cycle before the next start.
                    if (proc_done) begin
                        if (r_blk_addr == c_last_blk) begin
                            r_busy     <= 1'b0;
                            r_run_done <= 1'b1;
                            r_state    <= c_st_done;
                        end else begin
                            r_blk_addr <= r_blk_addr + 1'b1;
                            r_state    <= c_st_issue;
                        end
                    end
                end
                c_st_done: begin
                    if (!w_mode_any) begin
                        r_run_done <= 1'b0;
                        r_op       <= 3'd0;
                        r_blk_addr <= '0;
                        r_state    <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign op       = r_op;
    assign blk_addr = r_blk_addr;
    assign start    = r_start;
    assign busy     = r_busy;
    assign run_done = r_run_done;
    assign mode_err = r_mode_err;

endmodule
`default_nettype wire
